// File: rtl/rk4_pkg.sv
// rk4_pkg: shared Q8.8 constants, FSM state codes and saturating arithmetic helpers.
package rk4_pkg;
  localparam int W = 16;
  localparam int FRAC = 8;
  localparam logic [15:0] INV6 = 16'h2AAB;
  localparam logic signed [W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [W-1:0] SAT_MIN = 16'sh8000;
  localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_CALC = 2'd2, S_FINAL = 2'd3;
  typedef struct packed {
    logic signed [W-1:0] v;
    logic ovf;
  } sat_t;
  function automatic sat_t sat16(input logic signed [63:0] a);
    sat_t r;
    r.ovf = (a > 64'sd32767) || (a < -64'sd32768);
    r.v = (a > 64'sd32767) ? SAT_MAX : (a < -64'sd32768) ? SAT_MIN : a[W-1:0];
    return r;
  endfunction
  // Q8.8 x Q8.8: full product is Q16.16, arithmetic shift floors toward -inf
  function automatic sat_t qmul(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    logic signed [63:0] p;
    p = 64'(a) * 64'(b);
    return sat16(p >>> FRAC);
  endfunction
endpackage

// File: rtl/rk4_step_controller_if.sv
// rk4_step_controller_if: request/acknowledge link between the RK4 controller and the f(x,y) evaluator.
interface rk4_step_controller_if;
  logic f_req;
  logic f_ack;
  logic signed [rk4_pkg::W-1:0] f_x;
  logic signed [rk4_pkg::W-1:0] f_y;
  logic signed [rk4_pkg::W-1:0] f_dydx;
  modport master(output f_req, f_x, f_y, input f_ack, f_dydx);
  modport slave(input f_req, f_x, f_y, output f_ack, f_dydx);
endinterface

// File: rtl/rk4_stage_alu.sv
// rk4_stage_alu: combinational stage-operand generation and end-of-step x/y update.
module rk4_stage_alu
  import rk4_pkg::*;
(
    input  logic [1:0]          stage,
    input  logic signed [W-1:0] x,
    input  logic signed [W-1:0] y,
    input  logic signed [W-1:0] h,
    input  logic signed [W-1:0] k,
    input  logic signed [18:0]  sum,
    output logic signed [W-1:0] op_x,
    output logic signed [W-1:0] op_y,
    output logic                op_ovf,
    output logic signed [W-1:0] x_next,
    output logic signed [W-1:0] y_next,
    output logic                fin_ovf
);
    logic signed [W-1:0] hx;
    logic signed [63:0] delta;
    sat_t sx, sp, sy, nx, ny;
    always_comb begin
        hx = (stage == 2'd3) ? h : h >>> 1;
        sx = sat16(64'(x) + 64'(hx));
        sp = qmul(hx, k);
        sy = sat16(64'(y) + 64'(sp.v));
        // weighted k-sum times h, scaled by 1/6 in Q0.16, lands back in Q8.8
        delta = (64'(h) * 64'(sum) * $signed(64'(INV6))) >>> 24;
        ny = sat16(64'(y) + delta);
        nx = sat16(64'(x) + 64'(h));
        op_x = sx.v;
        op_y = sy.v;
        op_ovf = sx.ovf | sp.ovf | sy.ovf;
        x_next = nx.v;
        y_next = ny.v;
        fin_ovf = nx.ovf | ny.ovf;
    end
endmodule

// File: rtl/rk4_step_controller.sv
// rk4_step_controller: sequences the shared evaluator through the four RK4 stages for n_steps steps.
module rk4_step_controller
  import rk4_pkg::*;
#(
    parameter int STEP_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic signed [W-1:0] x0,
    input  logic signed [W-1:0] y0,
    input  logic signed [W-1:0] h,
    input  logic [STEP_W-1:0]   n_steps,
    rk4_step_controller_if.master ev,
    output logic                busy,
    output logic                step_valid,
    output logic signed [W-1:0] x_out,
    output logic signed [W-1:0] y_out,
    output logic [STEP_W-1:0]   step_idx,
    output logic                done,
    output logic                err_timeout,
    output logic                err_ovf
);
    localparam int TCW = $clog2(TIMEOUT + 1);
    logic [1:0] state, stage;
    logic signed [W-1:0] x, y, hr, k, fx, fy, op_x, op_y, x_next, y_next;
    logic signed [18:0] sum;
    logic [STEP_W-1:0] n, idx_next;
    logic [TCW-1:0] tcnt;
    logic op_ovf, fin_ovf;

    assign ev.f_req = (state == S_REQ);
    assign ev.f_x = fx;
    assign ev.f_y = fy;
    assign idx_next = step_idx + STEP_W'(1);

    // the ALU always prepares the operands of the stage that follows the current one
    rk4_stage_alu u_alu (
        .stage(stage + 2'd1), .x(x), .y(y), .h(hr), .k(k), .sum(sum),
        .op_x(op_x), .op_y(op_y), .op_ovf(op_ovf),
        .x_next(x_next), .y_next(y_next), .fin_ovf(fin_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE; stage <= '0; x <= '0; y <= '0; hr <= '0; k <= '0;
            fx <= '0; fy <= '0; sum <= '0; n <= '0; tcnt <= '0;
            busy <= 1'b0; step_valid <= 1'b0; done <= 1'b0; x_out <= '0; y_out <= '0;
            step_idx <= '0; err_timeout <= 1'b0; err_ovf <= 1'b0;
        end else begin
            step_valid <= 1'b0;
            done <= 1'b0;
            if (state != S_IDLE && abort) begin
                state <= S_IDLE;
                busy <= 1'b0;
            end else begin
                case (state)
                    S_REQ:
                        if (ev.f_ack) begin
                            k <= ev.f_dydx;
                            state <= S_CALC;
                        end else if (tcnt == TCW'(TIMEOUT - 1)) begin
                            err_timeout <= 1'b1;
                            done <= 1'b1;
                            busy <= 1'b0;
                            state <= S_IDLE;
                        end else tcnt <= tcnt + TCW'(1);
                    S_CALC: begin
                        sum <= sum + ((stage == 2'd0 || stage == 2'd3) ? 19'(k) : 19'(k) <<< 1);
                        stage <= stage + 2'd1;
                        tcnt <= '0;
                        if (stage == 2'd3) state <= S_FINAL;
                        else begin
                            fx <= op_x;
                            fy <= op_y;
                            err_ovf <= err_ovf | op_ovf;
                            state <= S_REQ;
                        end
                    end
                    S_FINAL: begin
                        x <= x_next; y <= y_next; x_out <= x_next; y_out <= y_next;
                        step_idx <= idx_next;
                        step_valid <= 1'b1;
                        err_ovf <= err_ovf | fin_ovf;
                        if (idx_next == n) begin
                            done <= 1'b1;
                            busy <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            fx <= x_next; fy <= y_next; sum <= '0; stage <= '0;
                            state <= S_REQ;
                        end
                    end
                    default:
                        if (start) begin
                            x <= x0; y <= y0; hr <= h; n <= n_steps;
                            fx <= x0; fy <= y0; sum <= '0; stage <= '0; tcnt <= '0;
                            step_idx <= '0; err_timeout <= 1'b0; err_ovf <= 1'b0;
                            if (n_steps == '0) begin
                                x_out <= x0;
                                y_out <= y0;
                                done <= 1'b1;
                            end else begin
                                busy <= 1'b1;
                                state <= S_REQ;
                            end
                        end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rk4_step_controller.sv
// tb_rk4_step_controller: directed and randomized runs checked against a behavioural RK4 model.
module tb_rk4_step_controller;
  logic clk = 0, rst_n = 0, start = 0, abort = 0;
  logic signed [15:0] x0 = 0, y0 = 0, h = 0;
  logic [7:0] n_steps = 0;
  logic busy, step_valid, done, err_timeout, err_ovf;
  logic signed [15:0] x_out, y_out;
  logic [7:0] step_idx;
  int nvec = 0, nerr = 0;
  int fmode = 0, ack_wait = 0, wcnt = 0, cyc = 0;
  longint fconst = 0;
  bit no_ack = 0, stray = 0, m_ovf = 0;
  logic [31:0] exp_ops[$], got_ops[$];
  logic signed [15:0] hold_x, hold_y;

  rk4_step_controller_if ev();
  rk4_step_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .x0(x0), .y0(y0), .h(h),
    .n_steps(n_steps), .ev(ev), .busy(busy), .step_valid(step_valid), .x_out(x_out),
    .y_out(y_out), .step_idx(step_idx), .done(done), .err_timeout(err_timeout), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > 32767) begin m_ovf = 1; return 32767; end
    if (v < -32768) begin m_ovf = 1; return -32768; end
    return v;
  endfunction

  function automatic longint fval(input longint fx, input longint fy);
    return (fmode == 0) ? fconst : ((fx - fy) >>> 2) + (fconst >>> 2);
  endfunction

  // one RK4 step straight from the textbook formulas, with Q8.8 floor and saturation
  function automatic void model_step(inout longint mx, inout longint my, input longint mh);
    longint k[4];
    longint px, py, off, s;
    for (int st = 0; st < 4; st++) begin
      off = (st == 0) ? 0 : (st == 3) ? mh : (mh >>> 1);
      px = mx; py = my;
      if (st != 0) begin
        px = sat(mx + off);
        py = sat(my + sat((off * k[st-1]) >>> 8));
      end
      exp_ops.push_back({16'(px), 16'(py)});
      k[st] = fval(px, py);
    end
    s = k[0] + 2 * k[1] + 2 * k[2] + k[3];
    my = sat(my + ((mh * s * 10923) >>> 24));
    mx = sat(mx + mh);
  endfunction

  // evaluator: acks after ack_wait cycles, records accepted operands, checks operand stability
  always @(negedge clk) begin
    if (ev.f_req === 1'b1) begin
      if (wcnt == 0) begin hold_x = ev.f_x; hold_y = ev.f_y; end
      else chk("operand_stable", {ev.f_x, ev.f_y}, {hold_x, hold_y});
      ev.f_ack = !no_ack && wcnt >= ack_wait;
      ev.f_dydx = 16'(fval(longint'(ev.f_x), longint'(ev.f_y)));
      if (ev.f_ack) begin got_ops.push_back({ev.f_x, ev.f_y}); wcnt = 0; end
      else wcnt++;
    end else begin
      ev.f_ack = stray;
      ev.f_dydx = 16'h5A5A;
      wcnt = 0;
    end
  end

  task automatic kick(input longint ax0, input longint ay0, input longint ah, input int an);
    @(negedge clk);
    x0 = 16'(ax0); y0 = 16'(ay0); h = 16'(ah); n_steps = 8'(an); start = 1;
    @(negedge clk);
    start = 0; cyc = 0;
  endtask

  task automatic run(input longint ax0, input longint ay0, input longint ah, input int an, input int aw);
    longint mx = ax0, my = ay0, ex[$], ey[$];
    int nsv = 0, period = 4 * (aw + 2) + 1;
    m_ovf = 0;
    exp_ops.delete(); got_ops.delete();
    for (int i = 0; i < an; i++) begin model_step(mx, my, ah); ex.push_back(mx); ey.push_back(my); end
    ack_wait = aw; no_ack = 0;
    kick(ax0, ay0, ah, an);
    chk("err_timeout_clr", err_timeout, 0);
    while (cyc < an * period + 10) begin
      if (step_valid) begin
        chk("sv_cycle", cyc, (nsv + 1) * period);
        if (nsv < an) begin
          chk("x_out", longint'(x_out), ex[nsv]);
          chk("y_out", longint'(y_out), ey[nsv]);
        end
        chk("step_idx", step_idx, nsv + 1);
        nsv++;
      end
      if (done) break;
      @(negedge clk); cyc++;
    end
    chk("done_seen", done, 1);
    chk("done_cycle", cyc, an * period);
    chk("done_with_sv", step_valid, an > 0);
    chk("steps", nsv, an);
    chk("busy_end", busy, 0);
    chk("y_final", longint'(y_out), an > 0 ? ey[an-1] : ay0);
    chk("x_final", longint'(x_out), an > 0 ? ex[an-1] : ax0);
    chk("err_ovf", err_ovf, m_ovf);
    chk("op_count", got_ops.size(), exp_ops.size());
    for (int i = 0; i < exp_ops.size() && i < got_ops.size(); i++) chk("op", got_ops[i], exp_ops[i]);
  endtask

  initial begin
    longint sx, sy;
    ev.f_ack = 0; ev.f_dydx = 0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {busy, step_valid, done, err_timeout, err_ovf, ev.f_req}, 0);
    chk("rst_data", {x_out, y_out, step_idx}, 0);
    rst_n = 1;

    fmode = 0; fconst = 'h100;
    run(0, 0, 'h100, 1, 0);
    chk("tp1_y", y_out, 16'h0100);
    chk("tp1_x", x_out, 16'h0100);
    chk("tp1_op3", got_ops.size() == 4 ? got_ops[3] : 0, 32'h0100_0100);
    run(0, 0, 'h40, 4, 0);
    chk("tp2_y", y_out, 16'h0100);
    chk("tp2_idx", step_idx, 4);
    fconst = 'h200;
    run(0, 0, 'h100, 1, 5);
    chk("tp3_y", y_out, 16'h0200);
    fconst = 'h7F00;
    run(0, 'h7000, 'h100, 1, 0);
    chk("tp4_y", y_out, 16'h7FFF);
    chk("tp4_ovf", err_ovf, 1);

    no_ack = 1;
    kick(0, 0, 'h100, 1);
    repeat (254) @(negedge clk);
    chk("to_req_held", {ev.f_req, err_timeout}, 2'b10);
    @(negedge clk);
    chk("to_flag", err_timeout, 1);
    chk("to_drop", {ev.f_req, busy, done}, 3'b001);
    fconst = 'h100;
    run('h10, 'h20, 'h80, 1, 1);

    fconst = 'h0C0; ack_wait = 0; no_ack = 0; m_ovf = 0;
    sx = 'h100; sy = 'h40;
    model_step(sx, sy, 'h80);
    kick('h100, 'h40, 'h80, 3);
    repeat (9) @(negedge clk);
    chk("ab_sv1", {step_valid, step_idx}, {1'b1, 8'd1});
    repeat (4) @(negedge clk);
    stray = 1;
    @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0; stray = 0;
    chk("ab_idle", {ev.f_req, busy, done, step_valid}, 0);
    chk("ab_hold", {x_out, y_out, step_idx}, {16'(sx), 16'(sy), 8'd1});
    cyc = 0;
    repeat (20) begin @(negedge clk); cyc += int'(done | step_valid | busy); end
    chk("ab_quiet", cyc, 0);

    run('h1234, -'h321, 'h100, 0, 0);

    no_ack = 1;
    kick('h300, 'h300, 'h100, 2);
    repeat (3) @(negedge clk);
    chk("rst_pre", ev.f_req, 1);
    #2 rst_n = 0;
    #1 chk("rst_async", {ev.f_req, busy, step_idx}, 0);
    @(negedge clk);
    rst_n = 1;
    no_ack = 0;

    for (int r = 0; r < 8; r++) begin
      fmode = int'($urandom_range(0, 1));
      fconst = longint'($urandom_range(0, 65535)) - 32768;
      run(longint'($urandom_range(0, 65535)) - 32768, longint'($urandom_range(0, 65535)) - 32768,
          (r < 4) ? longint'($urandom_range(0, 511)) - 256 : longint'($urandom_range(0, 65535)) - 32768,
          int'($urandom_range(1, 3)), int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/rk4_step_controller.md
Name: rk4_step_controller

Overview:
- Sequences a shared derivative evaluator (the f(x,y) block, Q8.8 in/out) through the four RK4 stages of each integration step. Runs n_steps consecutive steps.
- Forms every stage input and the weighted k-sum, and produces y_next = y + h*(k1+2k2+2k3+k4)/6.
- Sits between the top-level run control and the evaluator. It is the only requester of the evaluator.

Parameters:
- W, 16, data width; all x/y/h/dydx values are signed Q8.8.
- STEP_W, 8, width of the step count and step index.
- TIMEOUT, 255, maximum cycles f_req may stay high without f_ack before aborting.
- INV6, 16'h2AAB, 1/6 in unsigned Q0.16.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a run; sampled only in IDLE
- abort  in  1  synchronous cancel of a run in progress
- x0  in  W  initial x
- y0  in  W  initial y
- h  in  W  step size
- n_steps  in  STEP_W  number of steps to run
- f_req  out  1  evaluator request; held high until f_ack
- f_x  out  W  evaluator x operand; stable while f_req is high
- f_y  out  W  evaluator y operand; stable while f_req is high
- f_ack  in  1  evaluator result valid
- f_dydx  in  W  evaluator result; sampled when f_req and f_ack are both high
- busy  out  1  run in progress
- step_valid  out  1  one-cycle pulse per completed step
- x_out  out  W  x after the latest step
- y_out  out  W  y after the latest step
- step_idx  out  STEP_W  count of completed steps
- done  out  1  one-cycle pulse at run end
- err_timeout  out  1  sticky flag; cleared on the next accepted start
- err_ovf  out  1  sticky saturation flag; cleared on the next accepted start

Behaviour:
- Reset: all outputs 0; state IDLE; internal registers 0. Reset mid-run drops f_req immediately (asynchronous).
- States: IDLE, REQ, CALC, FINAL.
- IDLE:
  - start=1 latches x0, y0, h and n_steps, clears the error flags, and sets busy.
  - If n_steps=0: the next cycle sets x_out=x0, y_out=y0, pulses done, no step_valid, clears busy.
  - Otherwise go to REQ with stage=0.
- REQ:
  - f_req=1 with the operands of the current stage:
    - stage 0: (x, y)
    - stage 1: (x+h/2, y+(h/2)*k1)
    - stage 2: (x+h/2, y+(h/2)*k2)
    - stage 3: (x+h, y+h*k3)
  - h/2 is h>>>1.
  - On f_ack: capture f_dydx, drop f_req the following cycle, go to CALC. An ack on the first REQ cycle is legal.
  - A timeout counter runs from REQ entry. At TIMEOUT cycles without ack: set err_timeout, drop f_req, pulse done, go to IDLE.
- CALC (1 cycle):
  - Accumulate sum += k (stages 0 and 3) or 2k (stages 1 and 2). sum is a 19-bit signed register, cleared at each step start.
  - Compute the next stage operand, then go to REQ with stage+1. After stage 3, go to FINAL.
- FINAL (1 cycle):
  - delta = ((h*sum) * INV6) >>> 24, giving Q8.8.
  - y_next = sat16(y + delta); x_next = sat16(x + h).
- Step completion: on the edge after FINAL, update x_out and y_out, increment step_idx, and pulse step_valid.
  - If step_idx reaches n_steps: pulse done in the same cycle, clear busy, go to IDLE.
  - Otherwise go to REQ with stage 0.
- Step timing: with zero-wait ack, one step is 9 cycles (REQ/CALC ×4 plus FINAL).
- Multiplication: each h*k product is a 32-bit Q16.16 value; take bits [23:8] with arithmetic truncation toward -inf.
- Saturation: every 16-bit result saturates to 0x7FFF or 0x8000, and any saturation sets err_ovf. The run continues after saturation.
- abort=1 in any non-IDLE state:
  - Next cycle: IDLE, f_req=0, busy=0.
  - No done and no step_valid; x_out and y_out keep their last completed values.
  - Abort takes priority over a simultaneous f_ack or timeout.
- Spurious signals: f_ack outside REQ is ignored. start while busy is ignored.

Decomposition:
- Shared package rk4_pkg:
  - Q8.8 width and fraction constants.
  - The INV6 constant.
  - Saturation limits.
  - The state enumeration.
  - sat16 and qmul (Q8.8 × Q8.8 → Q8.8 with saturation flag) functions.
- One sub-module, rk4_stage_alu (combinational): stage-operand generation and the final y update. The FSM, counters and handshake stay in rk4_step_controller.

Test Plan:
- Evaluator returns constant 0x0100 with zero-wait ack; x0=0, y0=0, h=0x0100, n_steps=1:
  - f_x/f_y sequence (0,0), (0x0080,0x0080), (0x0080,0x0080), (0x0100,0x0100).
  - step_valid at cycle 9 after start; y_out=0x0100, x_out=0x0100; done with step_valid.
- Evaluator returns constant 0x0100; h=0x0040, y0=0, n_steps=4:
  - Four step_valid pulses; y_out = 0x0040, 0x0080, 0x00C0, 0x0100.
  - Final x_out=0x0100; step_idx=4; err_ovf=0.
- Evaluator returns constant 0x0200; h=0x0100, n_steps=1, ack delayed 5 cycles per request:
  - f_x/f_y held stable throughout each request; y_out=0x0200; total step latency 29 cycles.
- Evaluator returns 0x7F00; y0=0x7000, h=0x0100:
  - y_out=0x7FFF; err_ovf=1; done pulses normally.
- Evaluator never acks:
  - err_timeout=1 exactly TIMEOUT cycles after f_req rises; f_req=0 and busy=0 the next cycle; done pulses.
  - A following start clears err_timeout.
- Combined abort, idle and reset cases:
  - abort asserted in the CALC of stage 2 of step 2, in the same cycle as a stray f_ack: IDLE next cycle; y_out holds its step-1 value; no done.
  - n_steps=0: done one cycle after start with y_out=y0.
  - rst_n low mid-REQ: f_req=0 immediately.
